scroll_window: RTL and testbench

- Parametrised scrolling-window engine for the LED-matrix text path.
- Walks a circular message held in an external synchronous glyph-line ROM and fetches a window of DEPTH consecutive ROM lines starting at a scroll position.
- Publishes the window as a flat, tear-free (double-buffered) frame to the matrix driver.
- Adds over the previous generation: programmable scroll rate, direction, pause, non-power-of-two message length, ROM latency compensation, frame-valid strobe, and synchronous reset.

---
 rtl/scroll_pkg.sv | 21 ++
 rtl/scroll_tick.sv | 33 +++
 rtl/scroll_window.sv | 157 +++++++++++++++
 tb/tb_scroll_window.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling-window engine: FSM encoding and
// circular position arithmetic for a message of arbitrary length.
package scroll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL_REQ,
        ST_FILL,
        ST_COMMIT
    } state_t;

    // Compare-and-reset wrap keeps non-power-of-two lengths cheap.
    function automatic int unsigned wrap_inc(input int unsigned pos, input int unsigned msg_len);
        return (pos == msg_len - 1) ? 0 : pos + 1;
    endfunction

    function automatic int unsigned wrap_dec(input int unsigned pos, input int unsigned msg_len);
        return (pos == 0) ? msg_len - 1 : pos - 1;
    endfunction

endpackage

// File: rtl/scroll_tick.sv
// Programmable step-rate divider: pulses step once every max(div,1) enabled cycles.
module scroll_tick
    import scroll_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] period_m1;
    logic             wrap;

    // A period of 0 behaves as 1; ">=" lets a shortened period take hold at once.
    assign period_m1 = (div == '0) ? '0 : div - DIV_W'(1);
    assign wrap      = (count_reg >= period_m1);
    assign step      = en && wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (!en || wrap) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/scroll_window.sv
// Scrolling-window engine: fetches DEPTH consecutive lines of a circular message
// from a synchronous ROM into a shadow buffer and publishes them tear-free.
module scroll_window
    import scroll_pkg::*;
#(
    parameter int ROW_W   = 16,
    parameter int DEPTH   = 16,
    parameter int MSG_LEN = 64,
    parameter int ADDR_W  = 6,
    parameter int ROM_LAT = 1,
    parameter int DIV_W   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_dir,
    input  logic [DIV_W-1:0]       i_div,
    input  logic [ROW_W-1:0]       i_row,
    output logic [ADDR_W-1:0]      o_addr,
    output logic [ROW_W*DEPTH-1:0] o_buffer,
    output logic                   o_frame_valid,
    output logic [ADDR_W-1:0]      o_pos,
    output logic                   o_overrun
);

    localparam int FILL_CYC = DEPTH + ROM_LAT;
    localparam int CNT_W    = $clog2(FILL_CYC + 1);

    state_t                   state_reg;
    logic [ADDR_W-1:0]        pos_reg;
    logic [ADDR_W-1:0]        addr_reg;
    logic [ADDR_W-1:0]        pos_out_reg;
    logic [CNT_W-1:0]         fill_cnt_reg;
    logic                     pending_reg;
    logic                     frame_valid_reg;
    logic                     overrun_reg;
    logic [ROW_W*DEPTH-1:0]   buffer_reg;
    logic [ROW_W*DEPTH-1:0]   shadow_flat;

    logic                     step;
    logic [ADDR_W-1:0]        pos_fwd;
    logic [ADDR_W-1:0]        pos_bwd;
    logic [ADDR_W-1:0]        pos_step;
    logic [ADDR_W-1:0]        addr_inc;
    logic                     cap_en;
    logic [CNT_W-1:0]         cap_idx;
    logic                     busy;

    scroll_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (i_en),
        .div  (i_div),
        .step (step)
    );

    assign pos_fwd  = ADDR_W'(wrap_inc(32'(pos_reg), MSG_LEN));
    assign pos_bwd  = ADDR_W'(wrap_dec(32'(pos_reg), MSG_LEN));
    assign pos_step = i_dir ? pos_bwd : pos_fwd;
    assign addr_inc = ADDR_W'(wrap_inc(32'(addr_reg), MSG_LEN));

    // Fill cycle j returns the line issued ROM_LAT cycles earlier, i.e. line j-ROM_LAT.
    assign cap_en  = (state_reg == ST_FILL) && (fill_cnt_reg >= CNT_W'(ROM_LAT));
    assign cap_idx = fill_cnt_reg - CNT_W'(ROM_LAT);
    assign busy    = (state_reg == ST_FILL_REQ) || (state_reg == ST_FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_FILL_REQ;
            pos_reg         <= '0;
            addr_reg        <= '0;
            pos_out_reg     <= '0;
            fill_cnt_reg    <= '0;
            pending_reg     <= 1'b0;
            frame_valid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            buffer_reg      <= '0;
        end else begin
            frame_valid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pending_reg) begin
                        pos_reg     <= pos_step;
                        pending_reg <= step;
                        state_reg   <= ST_FILL_REQ;
                    end else if (step) begin
                        pos_reg   <= pos_step;
                        state_reg <= ST_FILL_REQ;
                    end
                end
                ST_FILL_REQ: begin
                    addr_reg     <= pos_reg;
                    fill_cnt_reg <= '0;
                    state_reg    <= ST_FILL;
                end
                ST_FILL: begin
                    if (fill_cnt_reg < CNT_W'(DEPTH - 1)) begin
                        addr_reg <= addr_inc;
                    end
                    if (fill_cnt_reg == CNT_W'(FILL_CYC - 1)) begin
                        state_reg <= ST_COMMIT;
                    end
                    fill_cnt_reg <= fill_cnt_reg + CNT_W'(1);
                end
                ST_COMMIT: begin
                    buffer_reg      <= shadow_flat;
                    pos_out_reg     <= pos_reg;
                    frame_valid_reg <= 1'b1;
                    // A step arriving in this cycle takes over the pending slot.
                    pending_reg     <= step;
                    if (pending_reg) begin
                        pos_reg   <= pos_step;
                        state_reg <= ST_FILL_REQ;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (busy && step) begin
                if (pending_reg) begin
                    overrun_reg <= 1'b1;
                end else begin
                    pending_reg <= 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_line
            logic [ROW_W-1:0] line_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    line_reg <= '0;
                end else if (cap_en && (cap_idx == CNT_W'(gi))) begin
                    line_reg <= i_row;
                end
            end

            assign shadow_flat[gi*ROW_W +: ROW_W] = line_reg;
        end
    endgenerate

    assign o_addr        = addr_reg;
    assign o_buffer      = buffer_reg;
    assign o_frame_valid = frame_valid_reg;
    assign o_pos         = pos_out_reg;
    assign o_overrun     = overrun_reg;

endmodule

// File: tb/tb_scroll_window.sv
// Directed bench for scroll_window: default build, a 3-cycle-latency ROM build
// and a 40-line message build, all driven by the same stimulus.
module tb_scroll_window;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dir;
    logic [23:0] div;

    logic [5:0]   a_addr, b_addr, c_addr;
    logic [255:0] a_buf, b_buf, c_buf;
    logic         a_fv, b_fv, c_fv;
    logic [5:0]   a_pos, b_pos, c_pos;
    logic         a_ovr, b_ovr, c_ovr;
    logic [15:0]  rom_a_q, rom_b1, rom_b2, rom_b3, rom_c_q;

    int cyc = 0;
    int frames = 0;
    int ovr_cnt = 0;
    int checks = 0;
    int passes = 0;
    int last_cyc;
    int f0;
    int ov0;

    always #5 clk = ~clk;

    scroll_window dut (
        .clk (clk), .rst (rst), .i_en (en), .i_dir (dir), .i_div (div),
        .i_row (rom_a_q), .o_addr (a_addr), .o_buffer (a_buf),
        .o_frame_valid (a_fv), .o_pos (a_pos), .o_overrun (a_ovr)
    );

    scroll_window #(.ROM_LAT (3)) dut_lat3 (
        .clk (clk), .rst (rst), .i_en (en), .i_dir (dir), .i_div (div),
        .i_row (rom_b3), .o_addr (b_addr), .o_buffer (b_buf),
        .o_frame_valid (b_fv), .o_pos (b_pos), .o_overrun (b_ovr)
    );

    scroll_window #(.MSG_LEN (40)) dut_msg40 (
        .clk (clk), .rst (rst), .i_en (en), .i_dir (dir), .i_div (div),
        .i_row (rom_c_q), .o_addr (c_addr), .o_buffer (c_buf),
        .o_frame_valid (c_fv), .o_pos (c_pos), .o_overrun (c_ovr)
    );

    // ROM[a] = a, with one or three cycles of read latency.
    always @(posedge clk) begin
        rom_a_q <= {10'd0, a_addr};
        rom_b1  <= {10'd0, b_addr};
        rom_b2  <= rom_b1;
        rom_b3  <= rom_b2;
        rom_c_q <= {10'd0, c_addr};
        cyc     <= cyc + 1;
    end

    always @(negedge clk) begin
        if (a_fv === 1'b1) frames++;
        if (a_ovr === 1'b1) ovr_cnt++;
    end

    function automatic logic [255:0] exp_buf(input int pos, input int len);
        logic [255:0] v = '0;
        for (int k = 0; k < 16; k++) begin
            v[k*16 +: 16] = 16'((pos + k) % len);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic wait_frame(input int max_cyc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (a_fv !== 1'b1 && n < max_cyc);
        if (a_fv !== 1'b1) begin
            checks++;
            $error("FAIL frame_timeout: observed no frame_valid, required one within %0d cycles", max_cyc);
        end else begin
            $display("frame pos=%0d cycle=%0d", a_pos, cyc);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; div = 24'd100;
        repeat (3) tick();
        chk("rst_buffer", a_buf, '0);
        chk("rst_pos", a_pos, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_fv", a_fv, 0);
        chk("rst_ovr", a_ovr, 0);
        chk("rst_ovr_lat3", b_ovr, 0);
        chk("rst_ovr_msg40", c_ovr, 0);

        // First frame 19 cycles after reset release, with scrolling disabled.
        rst = 1'b0;
        repeat (18) tick();
        chk("first_not_yet", a_fv, 0);
        tick();
        chk("first_fv", a_fv, 1);
        chk("first_buf", a_buf, exp_buf(0, 64));
        chk("first_pos", a_pos, 0);
        chk("msg40_first_fv", c_fv, 1);
        chk("msg40_first_buf", c_buf, exp_buf(0, 40));
        chk("lat3_not_yet", b_fv, 0);
        tick();
        tick();
        chk("lat3_fv", b_fv, 1);
        chk("lat3_buf", b_buf, exp_buf(0, 64));
        chk("lat3_pos", b_pos, 0);
        repeat (50) tick();
        chk("frozen_frames", frames, 1);

        // Forward scrolling every 100 cycles.
        en = 1'b1;
        wait_frame(300);
        chk("fwd_pos1", a_pos, 1);
        last_cyc = cyc;
        wait_frame(300);
        chk("fwd_pos2", a_pos, 2);
        chk("fwd_interval2", cyc - last_cyc, 100);
        last_cyc = cyc;
        wait_frame(300);
        chk("fwd_pos3", a_pos, 3);
        chk("fwd_interval3", cyc - last_cyc, 100);

        // Faster rate up to the straddling window at pos 60.
        div = 24'd25;
        for (int n = 0; n < 70 && a_pos !== 6'd60; n++) begin
            wait_frame(200);
            if (a_pos === 6'd40) chk("msg40_wrap_at40", c_pos, 0);
        end
        en = 1'b0;
        chk("straddle_pos", a_pos, 60);
        chk("straddle_buf", a_buf, exp_buf(60, 64));
        chk("msg40_pos20", c_pos, 20);
        chk("msg40_buf20", c_buf, exp_buf(20, 40));
        tick();
        tick();
        chk("lat3_straddle_buf", b_buf, exp_buf(60, 64));

        // Reset clears the frame; a second reset mid-fill aborts that fill.
        rst = 1'b1;
        tick();
        chk("rst2_buf", a_buf, '0);
        chk("rst2_pos", a_pos, 0);
        rst = 1'b0;
        repeat (8) tick();
        f0 = frames;
        rst = 1'b1;
        tick();
        chk("midfill_buf", a_buf, '0);
        chk("midfill_fv", a_fv, 0);
        rst = 1'b0;
        repeat (18) tick();
        chk("midfill_no_fv", frames, f0);
        tick();
        chk("restart_fv", a_fv, 1);
        chk("restart_pos", a_pos, 0);
        chk("restart_buf", a_buf, exp_buf(0, 64));

        // Backward from pos 0 wraps to the message end.
        dir = 1'b1; en = 1'b1; div = 24'd100;
        wait_frame(300);
        en = 1'b0;
        chk("bwd_pos", a_pos, 63);
        chk("bwd_buf", a_buf, exp_buf(63, 64));
        chk("msg40_bwd_pos", c_pos, 39);
        chk("msg40_bwd_buf", c_buf, exp_buf(39, 40));

        // Step every cycle: one deferred step per fill, the rest overrun.
        dir = 1'b0; div = 24'd1; en = 1'b1;
        wait_frame(100);
        chk("fast_pos0", a_pos, 0);
        chk("msg40_fwd_wrap", c_pos, 0);
        last_cyc = cyc;
        wait_frame(100);
        chk("fast_pos1", a_pos, 1);
        chk("fast_interval1", cyc - last_cyc, 19);
        last_cyc = cyc;
        ov0 = ovr_cnt;
        wait_frame(100);
        chk("fast_pos2", a_pos, 2);
        chk("fast_interval2", cyc - last_cyc, 19);
        chk("fast_overruns", ovr_cnt - ov0, 18);
        div = 24'd0;
        last_cyc = cyc;
        wait_frame(100);
        chk("div0_pos3", a_pos, 3);
        chk("div0_interval", cyc - last_cyc, 19);
        wait_frame(100);
        chk("div0_pos4", a_pos, 4);

        en = 1'b0;
        repeat (40) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
